// File: rtl/bin_pkg.sv
// Shared constants and helpers for the 3x3 binary neighbourhood filter.
package bin_pkg;

  // Width of a 3x3 window count (0..9).
  localparam int CNT_W    = 4;
  // Cycles from input pixel c to output pixel c.
  localparam int PIPE_LAT = 2;

  // Number of ones in a 3x3 window, packed as three 3-bit column vectors.
  function automatic logic [CNT_W-1:0] popcount9(input logic [8:0] win);
    logic [CNT_W-1:0] sum;
    sum = {CNT_W{1'b0}};
    for (int i = 0; i < 9; i++) begin
      sum = sum + {{(CNT_W-1){1'b0}}, win[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/bin_line_buffer.sv
// Single-bit line delay: dout is the bit written DEPTH enabled cycles earlier.
module bin_line_buffer #(
  parameter int DEPTH = 640
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_r;

  // Shift one position per active pixel; cleared by reset so no stale row survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_r <= {DEPTH{1'b0}};
    end else if (en) begin
      sr_r <= {sr_r[DEPTH-2:0], din};
    end else begin
      sr_r <= sr_r;
    end
  end

  assign dout = sr_r[DEPTH-1];

endmodule

// File: rtl/bin_compare_3x3.sv
// Streaming 3x3 binary neighbourhood count with run-time threshold.
// Output row r is produced while input row r+1 streams in; the last row is
// produced from an internally generated flush row whose bottom line is zero.
module bin_compare_3x3
  import bin_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] thresh,
  input  logic             per_img_vsync,
  input  logic             per_img_href,
  input  logic             per_img_bit,
  output logic             post_img_vsync,
  output logic             post_img_href,
  output logic             post_img_bit
);

  localparam int COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int ROW_W = $clog2(IMG_VDISP + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_HDISP - 1);
  localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_VDISP - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);

  // Frame tracking
  logic             vs_low_r;     // vsync seen low since reset (arms rise detect)
  logic             frame_act_r;  // inside a frame that started after reset
  logic             href_d_r;
  logic [ROW_W-1:0] in_row_r;     // input lines completed in this frame
  logic [COL_W-1:0] col_r;        // column of the current active pixel
  logic             flush_r;      // generating the virtual bottom row
  logic             last_r;       // right-edge evaluation cycle
  logic             last_flush_r; // right-edge evaluation of the last output row
  logic             vs_dly_r [PIPE_LAT-1];

  // Window column pipeline: a = previous column, b = the one before
  logic [2:0]       col_a_r;
  logic [2:0]       col_b_r;

  // Registered outputs
  logic             post_vsync_r;
  logic             post_href_r;
  logic             post_bit_r;

  // Combinational
  logic             vs_rise_s;
  logic             vs_gate_s;
  logic             href_s;
  logic             active_s;
  logic             fall_s;
  logic             flush_go_s;
  logic             row_ok_s;
  logic             bot_s;
  logic             top_s;
  logic [2:0]       vec_s;
  logic [2:0]       right_s;
  logic             eval_s;
  logic [CNT_W-1:0] count_s;
  logic             hit_s;
  logic             tail_s;
  logic             lb1_q_s;
  logic             lb2_q_s;

  bin_line_buffer #(.DEPTH(IMG_HDISP)) u_lb1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (active_s),
    .din  (bot_s),
    .dout (lb1_q_s)
  );

  bin_line_buffer #(.DEPTH(IMG_HDISP)) u_lb2 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (active_s),
    .din  (lb1_q_s),
    .dout (lb2_q_s)
  );

  // Qualify frame/line activity and assemble this cycle's column vector {top, mid, bottom}.
  always_comb begin
    vs_rise_s  = per_img_vsync & vs_low_r;
    vs_gate_s  = per_img_vsync & (frame_act_r | vs_rise_s);
    href_s     = per_img_href & frame_act_r;
    active_s   = href_s | flush_r;
    fall_s     = href_d_r & ~href_s;
    flush_go_s = fall_s & (in_row_r == ROW_LAST);
    row_ok_s   = flush_r | (in_row_r != ROW_ZERO);
    bot_s      = per_img_bit & href_s & ~flush_r;
    tail_s     = flush_go_s | flush_r | last_flush_r;
    // Output row 0 has no row above it; the line buffer still holds an old row.
    if (!flush_r && (in_row_r == ROW_ONE)) begin
      top_s = 1'b0;
    end else begin
      top_s = lb2_q_s;
    end
    vec_s = {top_s, lb1_q_s, bot_s};
  end

  // Evaluate the window centred on the previous column; right column is padding at row end.
  always_comb begin
    if (last_r) begin
      right_s = 3'b000;
    end else begin
      right_s = vec_s;
    end
    eval_s  = last_r | (active_s & row_ok_s & (col_r != COL_ZERO));
    count_s = popcount9({col_b_r, col_a_r, right_s});
    hit_s   = (count_s >= thresh);
  end

  // Frame start detection, row/column counting and flush sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_low_r     <= 1'b0;
      frame_act_r  <= 1'b0;
      href_d_r     <= 1'b0;
      in_row_r     <= ROW_ZERO;
      col_r        <= COL_ZERO;
      flush_r      <= 1'b0;
      last_r       <= 1'b0;
      last_flush_r <= 1'b0;
    end else begin
      vs_low_r     <= ~per_img_vsync;
      href_d_r     <= href_s;
      last_r       <= active_s & row_ok_s & (col_r == COL_LAST);
      last_flush_r <= flush_r & (col_r == COL_LAST);

      if (vs_rise_s) begin
        frame_act_r <= 1'b1;
      end else if (!per_img_vsync) begin
        frame_act_r <= 1'b0;
      end else begin
        frame_act_r <= frame_act_r;
      end

      if (vs_rise_s) begin
        in_row_r <= ROW_ZERO;
      end else if (fall_s) begin
        in_row_r <= in_row_r + ROW_ONE;
      end else begin
        in_row_r <= in_row_r;
      end

      if (vs_rise_s || !active_s || (col_r == COL_LAST)) begin
        col_r <= COL_ZERO;
      end else begin
        col_r <= col_r + COL_W'(1);
      end

      if (vs_rise_s) begin
        flush_r <= 1'b0;
      end else if (flush_go_s) begin
        flush_r <= 1'b1;
      end else if (flush_r && (col_r == COL_LAST)) begin
        flush_r <= 1'b0;
      end else begin
        flush_r <= flush_r;
      end
    end
  end

  // Shift column vectors through the window; left neighbour of column 0 is padding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_a_r <= 3'b000;
      col_b_r <= 3'b000;
    end else if (active_s) begin
      col_a_r <= vec_s;
      if (col_r == COL_ZERO) begin
        col_b_r <= 3'b000;
      end else begin
        col_b_r <= col_a_r;
      end
    end else begin
      col_a_r <= col_a_r;
      col_b_r <= col_b_r;
    end
  end

  // Delay the frame-qualified vsync to line up with the pixel pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
        vs_dly_r[i] <= 1'b0;
      end
    end else begin
      vs_dly_r[0] <= vs_gate_s;
      for (int i = 1; i < PIPE_LAT - 1; i++) begin
        vs_dly_r[i] <= vs_dly_r[i-1];
      end
    end
  end

  // Output register: vsync is stretched until the last row has been emitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_vsync_r <= 1'b0;
      post_href_r  <= 1'b0;
      post_bit_r   <= 1'b0;
    end else begin
      post_vsync_r <= vs_dly_r[PIPE_LAT-2] | tail_s;
      post_href_r  <= eval_s;
      post_bit_r   <= eval_s & hit_s;
    end
  end

  assign post_img_vsync = post_vsync_r;
  assign post_img_href  = post_href_r;
  assign post_img_bit   = post_bit_r;

endmodule

// File: tb/tb_bin_compare_3x3.sv
// Bench for bin_compare_3x3: an 8x6 instance cascaded into a second one.
module tb_bin_compare_3x3;

  localparam int W = 8;
  localparam int H = 6;

  typedef logic [H-1:0][W-1:0] frame_t;

  typedef struct {
    frame_t     img;
    logic [3:0] th;
    frame_t     exp;
    int         gap;
    int         tail;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] thresh_a, thresh_b;
  logic       vs, href, bit_in;
  logic       a_vs, a_href, a_bit;
  logic       b_vs, b_href, b_bit;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int drv_vs_rise, drv_vs_fall;
  int row_start [H];

  // Monitor state
  bit     clr_req = 1'b0;
  bit     clr_ack_a = 1'b0, clr_ack_b = 1'b0;
  frame_t cap_a, cap_b;
  int     lines_a, col_a, lines_b, col_b;
  int     len_a [H];
  int     len_b [H];
  int     start_a [H];
  logic   prev_href_a, prev_vs_a, prev_href_b;
  int     vs_rise_a, vs_fall_a, last_px_a;

  bin_compare_3x3 #(.IMG_HDISP(W), .IMG_VDISP(H)) dut_a (
    .clk(clk), .rst_n(rst_n), .thresh(thresh_a),
    .per_img_vsync(vs), .per_img_href(href), .per_img_bit(bit_in),
    .post_img_vsync(a_vs), .post_img_href(a_href), .post_img_bit(a_bit)
  );

  bin_compare_3x3 #(.IMG_HDISP(W), .IMG_VDISP(H)) dut_b (
    .clk(clk), .rst_n(rst_n), .thresh(thresh_b),
    .per_img_vsync(a_vs), .per_img_href(a_href), .per_img_bit(a_bit),
    .post_img_vsync(b_vs), .post_img_href(b_href), .post_img_bit(b_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // capture of the first instance's output frame and timing
  always @(negedge clk) begin
    if (clr_req != clr_ack_a) begin
      clr_ack_a   <= clr_req;
      lines_a     <= 0;
      col_a       <= 0;
      prev_href_a <= 1'b0;
      prev_vs_a   <= a_vs;
      vs_rise_a   <= -1;
      vs_fall_a   <= -1;
      last_px_a   <= -1;
      cap_a       <= '0;
      for (int i = 0; i < H; i++) begin
        len_a[i]   <= 0;
        start_a[i] <= -1;
      end
    end else begin
      prev_href_a <= a_href;
      prev_vs_a   <= a_vs;
      if (a_vs && !prev_vs_a && vs_rise_a < 0) vs_rise_a <= cyc;
      if (!a_vs && prev_vs_a && vs_fall_a < 0) vs_fall_a <= cyc;
      if (a_href) begin
        if (col_a == 0 && lines_a < H) start_a[lines_a] <= cyc;
        if (lines_a < H && col_a < W) cap_a[lines_a][col_a] <= a_bit;
        col_a     <= col_a + 1;
        last_px_a <= cyc;
      end else if (prev_href_a) begin
        if (lines_a < H) len_a[lines_a] <= col_a;
        lines_a <= lines_a + 1;
        col_a   <= 0;
      end
    end
  end

  // capture of the cascaded instance's output frame
  always @(negedge clk) begin
    if (clr_req != clr_ack_b) begin
      clr_ack_b   <= clr_req;
      lines_b     <= 0;
      col_b       <= 0;
      prev_href_b <= 1'b0;
      cap_b       <= '0;
      for (int i = 0; i < H; i++) len_b[i] <= 0;
    end else begin
      prev_href_b <= b_href;
      if (b_href) begin
        if (lines_b < H && col_b < W) cap_b[lines_b][col_b] <= b_bit;
        col_b <= col_b + 1;
      end else if (prev_href_b) begin
        if (lines_b < H) len_b[lines_b] <= col_b;
        lines_b <= lines_b + 1;
        col_b   <= 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: count ones in the zero-padded 3x3 neighbourhood and compare.
  function automatic frame_t model(input frame_t img, input logic [3:0] th);
    frame_t o;
    int n, rr, cc;
    o = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) n += int'(img[rr][cc]);
          end
        end
        o[r][c] = (n >= int'(th));
      end
    end
    return o;
  endfunction

  task automatic drive_frame(input frame_t img, input int gap, input int tail);
    clr_req = ~clr_req;
    vs = 1'b0; href = 1'b0; bit_in = 1'b0;
    tick; tick;
    vs = 1'b1;
    drv_vs_rise = cyc;
    tick; tick;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        href   = 1'b1;
        bit_in = img[r][c];
        if (c == 0) row_start[r] = cyc;
        tick;
      end
      href = 1'b0; bit_in = 1'b0;
      if (r < H - 1) repeat (gap) tick;
      else repeat (tail) tick;
    end
    vs = 1'b0;
    drv_vs_fall = cyc;
    repeat (40) tick;
  endtask

  task automatic check_a(input string tag, input frame_t exp);
    int exp_fall;
    chk($sformatf("%s_a_lines", tag), 64'(lines_a), 64'(H));
    for (int r = 0; r < H; r++) begin
      chk($sformatf("%s_a_row%0d", tag, r), 64'(cap_a[r]), 64'(exp[r]));
      chk($sformatf("%s_a_len%0d", tag, r), 64'(len_a[r]), 64'(W));
    end
    for (int r = 1; r < H; r++)
      chk($sformatf("%s_href_dly_row%0d", tag, r), 64'(start_a[r-1]), 64'(row_start[r] + 2));
    chk($sformatf("%s_vs_rise", tag), 64'(vs_rise_a), 64'(drv_vs_rise + 2));
    exp_fall = (drv_vs_fall + 2 > last_px_a + 1) ? drv_vs_fall + 2 : last_px_a + 1;
    chk($sformatf("%s_vs_fall", tag), 64'(vs_fall_a), 64'(exp_fall));
  endtask

  task automatic check_b(input string tag, input frame_t exp);
    chk($sformatf("%s_b_lines", tag), 64'(lines_b), 64'(H));
    for (int r = 0; r < H; r++) begin
      chk($sformatf("%s_b_row%0d", tag, r), 64'(cap_b[r]), 64'(exp[r]));
      chk($sformatf("%s_b_len%0d", tag, r), 64'(len_b[r]), 64'(W));
    end
  endtask

  task automatic run_cascade(input string tag, input int gap);
    frame_t img, mid;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = ($urandom_range(0, 99) < 60);
    thresh_a = 4'd6;
    thresh_b = 4'd3;
    drive_frame(img, gap, 2);
    mid = model(img, 4'd6);
    check_a(tag, mid);
    check_b(tag, model(mid, 4'd3));
  endtask

  vec_t   tbl [9];
  frame_t zero_f, ones_f, dot_f;

  initial begin
    zero_f = '0;
    ones_f = '1;
    dot_f  = {8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00};
    tbl[0] = '{img: zero_f, th: 4'd1,  exp: zero_f, gap: 3,  tail: 2};
    tbl[1] = '{img: ones_f, th: 4'd9,  exp: {8'h00, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h00}, gap: 10, tail: 1};
    tbl[2] = '{img: ones_f, th: 4'd4,  exp: ones_f, gap: 1,  tail: 30};
    tbl[3] = '{img: dot_f,  th: 4'd1,  exp: {8'h00, 8'h1C, 8'h1C, 8'h1C, 8'h00, 8'h00}, gap: 2, tail: 0};
    tbl[4] = '{img: dot_f,  th: 4'd2,  exp: zero_f, gap: 5,  tail: 3};
    tbl[5] = '{img: ones_f, th: 4'd6,  exp: {8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E}, gap: 1, tail: 2};
    tbl[6] = '{img: zero_f, th: 4'd0,  exp: ones_f, gap: 4,  tail: 2};
    tbl[7] = '{img: ones_f, th: 4'd10, exp: zero_f, gap: 2,  tail: 2};
    tbl[8] = '{img: ones_f, th: 4'd15, exp: zero_f, gap: 1,  tail: 25};

    rst_n = 1'b0; vs = 1'b0; href = 1'b0; bit_in = 1'b0;
    thresh_a = 4'd1; thresh_b = 4'd3;
    tick; tick; tick;
    chk("reset_outputs", {58'd0, a_vs, a_href, a_bit, b_vs, b_href, b_bit}, 64'd0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 9; i++) begin
      thresh_a = tbl[i].th;
      drive_frame(tbl[i].img, tbl[i].gap, tbl[i].tail);
      check_a($sformatf("vec%0d", i), tbl[i].exp);
    end

    run_cascade("casc_gap10", 10);
    run_cascade("casc_gap1", 1);
    run_cascade("casc2_gap10", 10);
    run_cascade("casc2_gap1", 1);

    // Mid-frame reset: abort after three rows, then a clean frame must be exact.
    thresh_a = 4'd6; thresh_b = 4'd3;
    vs = 1'b0; href = 1'b0; tick; tick;
    vs = 1'b1; tick; tick;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        href = 1'b1; bit_in = 1'b1; tick;
      end
      href = 1'b0; bit_in = 1'b0;
      repeat (4) tick;
    end
    rst_n = 1'b0;
    tick; tick;
    for (int k = 0; k < 4; k++) begin
      href = 1'b1; bit_in = 1'b1;
      chk($sformatf("in_reset_out%0d", k), {58'd0, a_vs, a_href, a_bit, b_vs, b_href, b_bit}, 64'd0);
      tick;
    end
    href = 1'b0; bit_in = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk($sformatf("post_reset_wait%0d", k), {60'd0, a_vs, a_href, b_vs, b_href}, 64'd0);
    end
    run_cascade("after_reset", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
